// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing the sprite ROM between NUM_REQ renderers.
// One fetch at a time: grant, wait out the ROM latency, return the row with a one-cycle ack.
module sprite_fetch_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SPRITE_W = 3,
    parameter int ROW_BITS = 26,
    parameter int ROM_LAT  = 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SPRITE_W-1:0]  req_sprite,
    input  logic [NUM_REQ*4-1:0]         req_row,
    output logic [SPRITE_W+3:0]          rom_addr,
    input  logic [ROW_BITS-1:0]          rom_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [ROW_BITS-1:0]          resp_data,
    output logic                         resp_valid,
    output logic                         busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t           state, next_state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] pick;
    logic             pick_valid;
    logic [1:0]       wait_cnt;
    int               idx;

    // Scan from rr_ptr upward (wrapping) so the last winner has lowest priority.
    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick       = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (pick_valid) next_state = ST_WAIT;
            ST_WAIT: if (wait_cnt == LAT_LAST) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Request is latched at grant; nothing on the req side matters until the next IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr    <= '0;
            winner    <= '0;
            rom_addr  <= '0;
            resp_data <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (pick_valid) begin
                        winner   <= pick;
                        rom_addr <= {req_sprite[pick*SPRITE_W +: SPRITE_W], req_row[pick*4 +: 4]};
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == LAT_LAST) resp_data <= rom_data;
                end
                ST_RESP: begin
                    rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack        = '0;
        resp_valid = (state == ST_RESP);
        busy       = (state != ST_IDLE);
        if (state == ST_RESP) ack[winner] = 1'b1;
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Randomized scoreboard bench for sprite_fetch_arbiter with a transaction-level arbitration model.
module tb_sprite_fetch_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int SPRITE_W = 3;
    localparam int ROW_BITS = 26;
    localparam int ROM_LAT  = 1;
    localparam logic [25:0] T2_WORD = 26'b10111100001101110000101111;

    logic                        Clk;
    logic                        Reset;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*SPRITE_W-1:0] req_sprite;
    logic [NUM_REQ*4-1:0]        req_row;
    logic [SPRITE_W+3:0]         rom_addr;
    logic [ROW_BITS-1:0]         rom_data;
    logic [NUM_REQ-1:0]          ack;
    logic [ROW_BITS-1:0]         resp_data;
    logic                        resp_valid;
    logic                        busy;

    sprite_fetch_arbiter #(
        .NUM_REQ(NUM_REQ), .SPRITE_W(SPRITE_W), .ROW_BITS(ROW_BITS), .ROM_LAT(ROM_LAT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_sprite(req_sprite), .req_row(req_row),
        .rom_addr(rom_addr), .rom_data(rom_data), .ack(ack), .resp_data(resp_data),
        .resp_valid(resp_valid), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM with ROM_LAT cycles of delay from the registered address
    logic [ROW_BITS-1:0]      rom [128];
    logic [3:0][ROW_BITS-1:0] rom_pipe;
    always @(posedge Clk) rom_pipe <= {rom_pipe[2:0], rom[rom_addr]};
    assign rom_data = (ROM_LAT == 0) ? rom[rom_addr] : rom_pipe[ROM_LAT-1];

    typedef struct {
        logic [NUM_REQ-1:0]  ack;
        logic [ROW_BITS-1:0] data;
        int                  cyc;
    } exp_t;

    exp_t                exp_q[$];
    int                  vectors     = 0;
    int                  miscompares = 0;
    int                  cyc         = 0;
    int                  m_ptr       = 0;
    int                  m_count     = 0;
    logic [SPRITE_W+3:0] m_addr      = '0;
    int                  resp_seen   = 0;
    bit                  mon_en      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*SPRITE_W-1:0] s,
                                 input logic [NUM_REQ*4-1:0] rw);
        req        = r;
        req_sprite = s;
        req_row    = rw;
    endtask

    task automatic drainIdle();
        int timed_out;
        timed_out = 1;
        applyStimulus('0, req_sprite, req_row);
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && m_count == 0) begin
                timed_out = 0;
                break;
            end
        end
        checkOutput("drain_idle", 32'(timed_out), 32'd0);
    endtask

    task automatic resetDut(input int n);
        Reset = 1'b1;
        repeat (n) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Reference model: every fetch occupies the ROM for ROM_LAT+3 cycles; between fetches the
    // requests are scanned round-robin starting after the previous winner.
    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
            if (Reset) begin
                exp_q.delete();
                m_ptr   = 0;
                m_count = 0;
            end else if (m_count > 0) begin
                m_count--;
            end else if (req != '0) begin
                int   w;
                exp_t e;
                w = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && req[i]) w = i;
                end
                m_addr   = {req_sprite[w*SPRITE_W +: SPRITE_W], req_row[w*4 +: 4]};
                e.ack    = NUM_REQ'(1) << w;
                e.data   = rom[m_addr];
                e.cyc    = cyc + ROM_LAT + 1;
                exp_q.push_back(e);
                m_ptr    = (w + 1) % NUM_REQ;
                m_count  = ROM_LAT + 2;
            end
        end
    end

    // Monitor: sampled on the falling edge, independent of the stimulus sequence
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                checkOutput("busy", 32'(busy), 32'(m_count != 0));
                if (m_count != 0) checkOutput("rom_addr_hold", 32'(rom_addr), 32'(m_addr));
                if (resp_valid) begin
                    resp_seen++;
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_resp_ack", 32'(ack), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("resp_ack", 32'(ack), 32'(e.ack));
                        checkOutput("resp_data", 32'(resp_data), 32'(e.data));
                        checkOutput("resp_latency", 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    checkOutput("ack_idle", 32'(ack), 32'd0);
                end
            end
        end
    end

    initial begin
        int base;
        int got;
        Reset = 1'b1;
        applyStimulus('1, '0, '0);
        for (int i = 0; i < 128; i++) rom[i] = ROW_BITS'($urandom);
        rom[4] = T2_WORD;

        // Reset held with every request up
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_resp_data", 32'(resp_data), 32'd0);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        Reset  = 1'b0;
        applyStimulus('0, '0, '0);
        base = resp_seen;
        repeat (6) @(negedge Clk);
        checkOutput("no_ack_after_reset", 32'(resp_seen - base), 32'd0);

        // Single fetch: requester 0, sprite 0, row 4
        applyStimulus(4'b0001, '0, 16'h0004);
        @(negedge Clk);
        checkOutput("t2_rom_addr", 32'(rom_addr), 32'h04);
        applyStimulus('0, '0, 16'h0004);
        repeat (3) @(negedge Clk);
        checkOutput("t2_resp_data", 32'(resp_data), 32'(T2_WORD));
        drainIdle();

        // All four requesting continuously
        resetDut(2);
        applyStimulus(4'hF, 12'($urandom), 16'($urandom));
        repeat (24) @(negedge Clk);
        drainIdle();

        // Only requesters 1 and 3
        applyStimulus(4'b1010, 12'($urandom), 16'($urandom));
        repeat (16) @(negedge Clk);
        drainIdle();

        // Requester 2 drops req and changes row right after the grant
        applyStimulus(4'b0100, 12'h5A3, 16'h0500);
        @(negedge Clk);
        applyStimulus(4'b0000, 12'h5A3, 16'h0900);
        base = resp_seen;
        drainIdle();
        checkOutput("t5_acked_once", 32'(resp_seen - base), 32'd1);

        // Reset while a fetch is in WAIT
        applyStimulus(4'hF, 12'($urandom), 16'($urandom));
        for (int n = 0; n < 10; n++) begin
            @(negedge Clk);
            if (m_count != 0) break;
        end
        resetDut(2);
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (resp_valid) begin
                got = 1;
                break;
            end
        end
        checkOutput("t6_resp_seen", 32'(got), 32'd1);
        checkOutput("t6_first_ack", 32'(ack), 32'd1);
        drainIdle();

        // Random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            Reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) applyStimulus(4'($urandom), 12'($urandom), 16'($urandom));
        end
        Reset = 1'b0;
        drainIdle();
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
